vote_collector: RTL and testbench
=================================

Name: vote_collector

Overview:
- Front-end stage that gathers one vote from each of three voters and produces the 3-bit vote vector consumed by the downstream majority voter.
- Synchronizes raw yes/no buttons and latches each voter's first press during a bounded voting window.
- Presents the closed round as a stable vector with a valid/ack handshake.

Parameters:
- WINDOW_CYCLES, 1000, length of the voting window in clk cycles (>= 2).
- CNT_W, 16, window counter width; WINDOW_CYCLES-1 must fit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that opens a round; honoured only in IDLE.
- btn_yes  input  3  raw asynchronous yes buttons, bit i = voter i.
- btn_no  input  3  raw asynchronous no buttons, bit i = voter i.
- ack  input  1  downstream has consumed the vector; honoured only in PRESENT.
- votes  output  3  latched yes votes (1 = yes; no/abstain = 0), feeds voter input.
- voted  output  3  voter i has cast a vote this round.
- valid  output  1  votes/voted/timed_out are stable and complete.
- busy  output  1  high in COLLECT.
- timed_out  output  1  round closed by window expiry with voted != 3'b111.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; votes=0, voted=0, valid=0, busy=0, timed_out=0; counter=0; synchronizer and edge flops cleared. Reset mid-round discards the round.
- Inputs: each of the 6 buttons passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
- Latency: a button rising before clk edge N sets voted[i] after edge N+2.
- FSM:
  - IDLE: valid=0, busy=0. On start, go to COLLECT, clear votes/voted/timed_out, and load counter=WINDOW_CYCLES-1.
  - COLLECT: busy=1. Counter decrements each cycle.
    - For voter i with voted[i]=0: a yes edge sets votes[i]=1 and voted[i]=1; a no edge sets votes[i]=0 and voted[i]=1.
    - Yes and no edges in the same cycle are both ignored for that voter.
    - Presses after voted[i]=1 are ignored.
    - Go to PRESENT when voted (registered) == 3'b111, or when counter==0; timed_out is set only if voted != 3'b111.
    - If the last vote latches on the same edge the counter reaches 0, the vote counts and timed_out=0 at close.
  - PRESENT: valid=1, busy=0; outputs frozen.
    - On ack, go to IDLE; valid deasserts on the following cycle. votes/voted hold until the next start.
- start outside IDLE and ack outside PRESENT are ignored; start and ack together in PRESENT: ack honoured, start ignored.
- Counter never wraps; it is held at 0 outside COLLECT.

Optional Feature:
- Macro: VOTE_CHANGE_EN.
- Defined: a voter may change a latched vote during COLLECT; the latest valid edge wins. The round closes only at counter==0, even if voted==3'b111 earlier. timed_out follows the same rule (voted != 3'b111 at close).
- Undefined: first-press-wins and early close, as above.

Decomposition:
- Package vote_pkg: state enum (IDLE, COLLECT, PRESENT), NUM_VOTERS=3, default WINDOW_CYCLES.
- Sub-module btn_sync_edge (parameter WIDTH): 2-flop synchronizer plus rising-edge pulse per bit with async active-low reset. Instantiated once with WIDTH=6.

Test Plan (WINDOW_CYCLES=20):
- Reset mid-COLLECT with voted=3'b011 -> all outputs 0 immediately; state IDLE; next start opens a clean round.
- start; yes0, no1, yes2 pressed at cycles 2, 4, 6 -> votes=3'b101, voted=3'b111, valid=1 one cycle after voted=3'b111; timed_out=0.
- start; only yes1 pressed; no further presses -> valid=1 at window end (~20 cycles after start); votes=3'b010, voted=3'b010, timed_out=1.
- Voter 0 presses yes then no; voter 1 presses yes and no in the same cycle; voter 1 later presses yes -> without macro: votes[0]=1, and voter 1 latches yes only on the later press. With VOTE_CHANGE_EN: votes[0]=0 at close.
- In PRESENT, hold ack=0 for 10 cycles and pulse start -> valid stays 1 and outputs unchanged. Then ack=1 -> valid=0 next cycle and state IDLE.
- Third vote edge lands on the counter==0 cycle -> voted=3'b111, timed_out=0, valid=1.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote collector front end.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int NUM_VOTERS        = 3;
    localparam int DEF_WINDOW_CYCLES = 1000;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer per bit followed by a one-cycle rising-edge pulse.
module btn_sync_edge #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter within a timed window and presents the closed round.
// Optional macro VOTE_CHANGE_EN: latest vote wins and the round always runs the full window.
//
// state   | meaning
// IDLE    | waiting for start; last round's votes/voted held
// COLLECT | window open, counter running, latching button edges
// PRESENT | round closed, outputs frozen until ack
module vote_collector
    import vote_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_VOTERS-1:0] btn_yes,
    input  logic [NUM_VOTERS-1:0] btn_no,
    input  logic                  ack,
    output logic [NUM_VOTERS-1:0] votes,
    output logic [NUM_VOTERS-1:0] voted,
    output logic                  valid,
    output logic                  busy,
    output logic                  timed_out
);

    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [NUM_VOTERS-1:0] ALL_VOTED = '1;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2*NUM_VOTERS-1:0] rise;
    logic [NUM_VOTERS-1:0]   yes_e;
    logic [NUM_VOTERS-1:0]   no_e;
    logic [NUM_VOTERS-1:0]   votes_nxt;
    logic [NUM_VOTERS-1:0]   voted_nxt;
    logic                    close;

    btn_sync_edge #(.WIDTH(2*NUM_VOTERS)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({btn_no, btn_yes}),
        .rise (rise)
    );

    assign yes_e = rise[NUM_VOTERS-1:0];
    assign no_e  = rise[2*NUM_VOTERS-1:NUM_VOTERS];

    // A simultaneous yes+no edge from one voter is ambiguous and dropped.
    always_comb begin
        votes_nxt = votes;
        voted_nxt = voted;
        for (int i = 0; i < NUM_VOTERS; i++) begin
`ifdef VOTE_CHANGE_EN
            if (yes_e[i] ^ no_e[i]) begin
`else
            if ((yes_e[i] ^ no_e[i]) && !voted[i]) begin
`endif
                votes_nxt[i] = yes_e[i];
                voted_nxt[i] = 1'b1;
            end
        end
    end

`ifdef VOTE_CHANGE_EN
    assign close = (cnt == '0);
`else
    assign close = (cnt == '0) || (voted == ALL_VOTED);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            votes     <= '0;
            voted     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        votes     <= '0;
                        voted     <= '0;
                        timed_out <= 1'b0;
                        cnt       <= CNT_LOAD;
                    end
                end
                COLLECT: begin
                    // A vote landing on the closing edge still counts toward timed_out.
                    votes <= votes_nxt;
                    voted <= voted_nxt;
                    if (close) begin
                        state     <= PRESENT;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        cnt       <= '0;
                        timed_out <= (voted_nxt != ALL_VOTED);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_collector.sv
// Directed, table-driven bench for vote_collector with WINDOW_CYCLES=20.
module tb_vote_collector;

    localparam int WIN = 20;
`ifdef VOTE_CHANGE_EN
    localparam int EARLY = 20;
`else
    localparam int EARLY = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] btn_yes;
    logic [2:0] btn_no;
    logic       ack;
    logic [2:0] votes;
    logic [2:0] voted;
    logic       valid;
    logic       busy;
    logic       timed_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int s_cyc   = 0;
    int lat     = 0;

    typedef struct {
        logic [2:0] yes;
        logic [2:0] no;
        logic [2:0] exp_votes;
        logic [2:0] exp_voted;
        logic       exp_to;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    vote_collector #(.WINDOW_CYCLES(WIN), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .btn_yes  (btn_yes),
        .btn_no   (btn_no),
        .ack      (ack),
        .votes    (votes),
        .voted    (voted),
        .valid    (valid),
        .busy     (busy),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] y, input logic [2:0] n);
        btn_yes = btn_yes | y;
        btn_no  = btn_no | n;
        tick();
        btn_yes = btn_yes & ~y;
        btn_no  = btn_no & ~n;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!valid && n < limit) begin
            tick();
            n++;
        end
        check("valid_wait", {31'd0, valid}, 32'd1);
        lat = cyc - s_cyc;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b101, 3'b010, 3'b101, 3'b111, 1'b0, EARLY};
        vecs[1] = '{3'b000, 3'b111, 3'b000, 3'b111, 1'b0, EARLY};
        vecs[2] = '{3'b010, 3'b000, 3'b010, 3'b010, 1'b1, WIN};
        vecs[3] = '{3'b011, 3'b001, 3'b010, 3'b010, 1'b1, WIN};
        vecs[4] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, WIN};
        vecs[5] = '{3'b111, 3'b111, 3'b000, 3'b000, 1'b1, WIN};

        rst_n = 1'b0; start = 1'b0; ack = 1'b0; btn_yes = '0; btn_no = '0;
        #3;
        check("reset_outputs", {23'd0, votes, voted, valid, busy, timed_out}, 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Reset mid-COLLECT with voted=011 discards the round.
        do_start();
        tick();
        press(3'b001, 3'b010);
        for (int n = 0; n < 10 && voted != 3'b011; n++) tick();
        check("pre_reset_voted", {29'd0, voted}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {23'd0, votes, voted, valid, busy, timed_out}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("idle_after_reset", {30'd0, valid, busy}, 32'd0);
        do_start();
        check("clean_round", {26'd0, busy, valid, votes, voted}, 32'h80);
        wait_valid(40);
        check("clean_round_lat", lat, WIN);
        check("clean_round_out", {25'd0, votes, voted, timed_out}, 32'h1);
        do_ack();

        // Table: all presses land together two cycles after start.
        for (int v = 0; v < 6; v++) begin
            do_start();
            tick_n(2);
            press(vecs[v].yes, vecs[v].no);
            wait_valid(40);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_votes", v), {29'd0, votes}, {29'd0, vecs[v].exp_votes});
            check($sformatf("vec%0d_voted", v), {29'd0, voted}, {29'd0, vecs[v].exp_voted});
            check($sformatf("vec%0d_to", v), {31'd0, timed_out}, {31'd0, vecs[v].exp_to});
            start = 1'b1;
            ack   = 1'b1;
            tick();
            start = 1'b0;
            ack   = 1'b0;
            check($sformatf("vec%0d_ack_valid", v), {30'd0, valid, busy}, 32'd0);
            tick();
            check($sformatf("vec%0d_start_ignored", v), {30'd0, valid, busy}, 32'd0);
        end

        // yes0, no1, yes2 at cycles 2, 4, 6.
        do_start();
        tick_n(2);
        press(3'b001, 3'b000);
        tick();
        press(3'b000, 3'b010);
        tick();
        press(3'b100, 3'b000);
        for (int n = 0; n < 10 && voted != 3'b111; n++) tick();
        check("seq_voted", {29'd0, voted}, 32'h7);
        check("seq_valid_before", {31'd0, valid}, 32'd0);
        tick();
`ifdef VOTE_CHANGE_EN
        check("seq_valid_after", {31'd0, valid}, 32'd0);
        wait_valid(40);
        check("seq_lat", lat, WIN);
`else
        check("seq_valid_after", {31'd0, valid}, 32'd1);
`endif
        check("seq_out", {25'd0, votes, voted, timed_out}, {25'd0, 3'b101, 3'b111, 1'b0});
        do_ack();

        // Vote change / conflicting edges / re-press.
        do_start();
        tick();
        press(3'b001, 3'b000);
        tick();
        press(3'b000, 3'b001);
        tick();
        press(3'b010, 3'b010);
        tick();
        press(3'b010, 3'b000);
        wait_valid(40);
        check("chg_lat", lat, WIN);
`ifdef VOTE_CHANGE_EN
        check("chg_votes", {29'd0, votes}, 32'h2);
`else
        check("chg_votes", {29'd0, votes}, 32'h3);
`endif
        check("chg_voted_to", {28'd0, voted, timed_out}, {28'd0, 3'b011, 1'b1});

        // PRESENT holds through a stray start; ack releases it.
        for (int k = 0; k < 10; k++) begin
            start = (k == 5);
            tick();
            check($sformatf("hold%0d", k), {23'd0, valid, busy, votes, voted, timed_out},
                  {23'd0, 1'b1, 1'b0, votes_expected_chg(), 3'b011, 1'b1});
        end
        start = 1'b0;
        do_ack();
        check("ack_valid", {30'd0, valid, busy}, 32'd0);
        check("ack_hold_votes", {29'd0, voted}, 32'h3);
        tick();
        check("idle_stays", {30'd0, valid, busy}, 32'd0);

        // Third vote latches on the edge where the counter reaches 0.
        do_start();
        tick_n(2);
        press(3'b011, 3'b000);
        tick_n(16 - (cyc - s_cyc));
        press(3'b100, 3'b000);
        wait_valid(40);
        check("last_edge_lat", lat, WIN);
        check("last_edge_out", {25'd0, votes, voted, timed_out}, {25'd0, 3'b111, 3'b111, 1'b0});
        do_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [2:0] votes_expected_chg();
`ifdef VOTE_CHANGE_EN
        return 3'b010;
`else
        return 3'b011;
`endif
    endfunction

endmodule
